ted_clock_enable_gen: RTL and testbench

- Sits directly downstream of the system PLL, which supplies 56.750336 MHz clk_sys and a locked flag.
- Derives every TED/CPU timing strobe used by the C16 core as single-cycle clock enables on clk_sys:
  - 28.375 MHz master enable
  - 7.09 MHz pixel enable
  - 1.77 / 0.886 MHz CPU enable
- Produces the core's reset, released only after the PLL has been locked and stable for a programmed hold time.

---
 rtl/ted_clock_enable_gen.sv | 163 ++++++++++++++++
 tb/tb_ted_clock_enable_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ted_clock_enable_gen.sv
// TED/CPU clock-enable generator and PLL-lock reset sequencer for the C16 core.
// Optional NTSC master-rate accumulator enabled by defining TED_CLKGEN_NTSC_EN.
module ted_clock_enable_gen #(
  parameter int unsigned RST_HOLD = 1024,
  parameter int unsigned NTSC_INC = 33070
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       ntsc,
  input  logic       fast,
  output logic       ce_28m,
  output logic       ce_pix,
  output logic       ce_cpu,
  output logic [4:0] phase,
  output logic       reset_out
);

  localparam logic [15:0] HoldLast = 16'(RST_HOLD - 1);

  logic        sync1_q, lock_s_q;
  logic [15:0] hold_q, hold_d;
  logic        reset_out_q, reset_out_d;
  logic        tog_q, tog_d;
  logic [4:0]  ph_next_q, ph_next_d;
  logic [4:0]  phase_q, phase_d;
  logic        ce_28m_q, ce_28m_d;
  logic        ce_pix_q, ce_pix_d;
  logic        ce_cpu_q, ce_cpu_d;
  logic        fast_q, fast_d;
  logic        run, tick, strobe;

`ifdef TED_CLKGEN_NTSC_EN
  logic        ntsc_q, ntsc_d;
  logic [15:0] acc_q, acc_d;
  logic [16:0] acc_sum;

  assign acc_sum = {1'b0, acc_q} + 17'(NTSC_INC);
  assign tick    = ntsc_q ? acc_sum[16] : tog_q;
`else
  logic [16:0] unused_ntsc;

  assign unused_ntsc = {ntsc, 16'(NTSC_INC)};
  assign tick        = tog_q;
`endif

  // Two-flop synchroniser: pll_locked is asynchronous to clk_sys.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;
    end
  end

  assign run    = lock_s_q && !reset_out_q;
  assign strobe = run && tick;

  always_comb begin
    reset_out_d = reset_out_q;
    hold_d      = hold_q;
    if (!lock_s_q) begin
      reset_out_d = 1'b1;
      hold_d      = '0;
    end else if (reset_out_q) begin
      if (hold_q == HoldLast) begin
        reset_out_d = 1'b0;
        hold_d      = '0;
      end else begin
        hold_d = hold_q + 16'd1;
      end
    end
  end

  always_comb begin
    tog_d     = tog_q;
    ph_next_d = ph_next_q;
    phase_d   = phase_q;
    ce_28m_d  = 1'b0;
    ce_pix_d  = 1'b0;
    ce_cpu_d  = 1'b0;
    fast_d    = fast_q;
`ifdef TED_CLKGEN_NTSC_EN
    ntsc_d    = ntsc_q;
    acc_d     = acc_q;
    // Source choice tracks the input while held in reset (phase is parked at 0).
    if (reset_out_q) ntsc_d = ntsc;
`endif
    if (!run) begin
      // Also covers the edge where lock is lost: the pending strobe is dropped.
      tog_d     = 1'b0;
      ph_next_d = '0;
      phase_d   = '0;
`ifdef TED_CLKGEN_NTSC_EN
      acc_d     = '0;
`endif
    end else begin
      tog_d = ~tog_q;
`ifdef TED_CLKGEN_NTSC_EN
      acc_d = acc_sum[15:0];
`endif
      if (strobe) begin
        ce_28m_d  = 1'b1;
        phase_d   = ph_next_q;
        ph_next_d = ph_next_q + 5'd1;
        ce_pix_d  = (ph_next_q[1:0] == 2'd3);
        ce_cpu_d  = fast_q ? (ph_next_q[3:0] == 4'd15) : (ph_next_q == 5'd31);
        // Speed and source only change at the end of a full 32-phase frame.
        if (ph_next_q == 5'd31) begin
          fast_d = fast;
`ifdef TED_CLKGEN_NTSC_EN
          ntsc_d = ntsc;
          if (ntsc != ntsc_q) begin
            acc_d = '0;
            tog_d = 1'b0;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hold_q      <= '0;
      reset_out_q <= 1'b1;
      tog_q       <= 1'b0;
      ph_next_q   <= '0;
      phase_q     <= '0;
      ce_28m_q    <= 1'b0;
      ce_pix_q    <= 1'b0;
      ce_cpu_q    <= 1'b0;
      fast_q      <= 1'b0;
`ifdef TED_CLKGEN_NTSC_EN
      ntsc_q      <= 1'b0;
      acc_q       <= '0;
`endif
    end else begin
      hold_q      <= hold_d;
      reset_out_q <= reset_out_d;
      tog_q       <= tog_d;
      ph_next_q   <= ph_next_d;
      phase_q     <= phase_d;
      ce_28m_q    <= ce_28m_d;
      ce_pix_q    <= ce_pix_d;
      ce_cpu_q    <= ce_cpu_d;
      fast_q      <= fast_d;
`ifdef TED_CLKGEN_NTSC_EN
      ntsc_q      <= ntsc_d;
      acc_q       <= acc_d;
`endif
    end
  end

  assign ce_28m    = ce_28m_q;
  assign ce_pix    = ce_pix_q;
  assign ce_cpu    = ce_cpu_q;
  assign phase     = phase_q;
  assign reset_out = reset_out_q;

endmodule

// File: tb/tb_ted_clock_enable_gen.sv
// Self-checking bench for ted_clock_enable_gen: lock sequencing, PAL rates,
// speed switch, lock glitch and async reset (NTSC rate when TED_CLKGEN_NTSC_EN).
module tb_ted_clock_enable_gen;

  localparam int unsigned Hold = 16;

  logic       clk_sys = 1'b0;
  logic       reset, pll_locked, ntsc, fast;
  logic       ce_28m, ce_pix, ce_cpu, reset_out;
  logic [4:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         edge_n;
    logic       rst;
    logic       ce;
    logic       pix;
    logic       cpu;
    logic [4:0] ph;
  } vec_t;

  vec_t lock_tab[100];
  vec_t sb_q[$];
  int   ph_q[$];

  ted_clock_enable_gen #(
    .RST_HOLD(Hold)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .pll_locked(pll_locked),
    .ntsc      (ntsc),
    .fast      (fast),
    .ce_28m    (ce_28m),
    .ce_pix    (ce_pix),
    .ce_cpu    (ce_cpu),
    .phase     (phase),
    .reset_out (reset_out)
  );

  always #5 clk_sys = ~clk_sys;

  // Advance one active edge and return on the following falling edge.
  task automatic tick();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {reset_out, ce_28m, ce_pix, ce_cpu, phase};
  endfunction

  initial begin
    int c28, cpix, ccpu, wide, bad_sp, last_cpu, waited;
    logic p28, ppix, pcpu;
    int t[4];
    int got;
    vec_t v, e;

    // Expected lock-release sequence, edge k counted from the pll_locked rise.
    for (int k = 1; k <= 100; k++) begin
      int started;
      started = (k >= 20);
      v.edge_n = k;
      v.rst    = (k < 18);
      v.ce     = started && ((k - 20) % 2 == 0);
      v.ph     = started ? 5'(((k - 20) / 2) % 32) : 5'd0;
      v.pix    = v.ce && (v.ph[1:0] == 2'd3);
      v.cpu    = v.ce && (v.ph == 5'd31);
      lock_tab[k-1] = v;
    end

    reset = 1'b1; pll_locked = 1'b0; ntsc = 1'b0; fast = 1'b0;
    repeat (5) tick();
    check("reset_state", 32'(outs()), 32'h100);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("unlocked[%0d]", i), 32'(reset_out), 32'd1);
    end

    pll_locked = 1'b1;
    for (int k = 0; k < 100; k++) begin
      sb_q.push_back(lock_tab[k]);
      tick();
      e = sb_q.pop_front();
      check($sformatf("lock_seq[%0d]", e.edge_n), 32'(outs()),
            32'({e.rst, e.ce, e.pix, e.cpu, e.ph}));
    end

    // PAL rates, fast = 0.
    c28 = 0; cpix = 0; ccpu = 0; wide = 0; bad_sp = 0; last_cpu = -1;
    p28 = 1'b0; ppix = 1'b0; pcpu = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      c28  += int'(ce_28m);
      cpix += int'(ce_pix);
      if ((ce_28m && p28) || (ce_pix && ppix) || (ce_cpu && pcpu)) wide++;
      if (ce_cpu) begin
        ccpu++;
        if (last_cpu >= 0 && i - last_cpu != 64) bad_sp++;
        last_cpu = i;
      end
      p28 = ce_28m; ppix = ce_pix; pcpu = ce_cpu;
    end
    check("pal_ce_28m_count", c28, 2048);
    check("pal_ce_pix_count", cpix, 512);
    check("pal_ce_cpu_count", ccpu, 64);
    check("pal_cpu_spacing_errors", bad_sp, 0);
    check("pal_wide_strobes", wide, 0);

    // Speed switch at phase 7.
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!(ce_28m && phase == 5'd7) && waited < 200);
    check("reach_phase7", 32'(ce_28m && phase == 5'd7), 32'd1);
    fast = 1'b1;
    ph_q.push_back(31); ph_q.push_back(15); ph_q.push_back(31); ph_q.push_back(15);
    got = 0;
    for (int i = 0; i < 400 && ph_q.size() > 0; i++) begin
      tick();
      if (ce_cpu) begin
        check($sformatf("speed_cpu_phase[%0d]", got), 32'(phase), 32'(ph_q.pop_front()));
        t[got] = i;
        got++;
      end
    end
    check("speed_cpu_strobes_seen", got, 4);
    for (int i = 1; i < 4; i++)
      if (i < got) check($sformatf("speed_cpu_spacing[%0d]", i), t[i] - t[i-1], 32);

    // One-cycle lock glitch.
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    tick();
    check("glitch_reset_rise", 32'(outs()), 32'h100);
    for (int r = 3; r <= 17; r++) begin
      tick();
      check($sformatf("glitch_hold[%0d]", r), 32'(outs()), 32'h100);
    end
    tick();
    check("glitch_release", 32'(outs()), 32'h000);
    tick();
    check("glitch_first_gap", 32'(outs()), 32'h000);
    tick();
    check("glitch_first_ce", 32'(outs()), 32'h080);

    // Asynchronous reset between edges, with phase already advanced.
    repeat (9) tick();
    check("pre_async_phase_nonzero", 32'(phase != 5'd0), 32'd1);
    #2 reset = 1'b1;
    #1 check("async_reset", 32'(outs()), 32'h100);
    #1 reset = 1'b0;

`ifdef TED_CLKGEN_NTSC_EN
    ntsc = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (reset_out && waited < Hold + 20);
    check("ntsc_release", 32'(reset_out), 32'd0);
    c28 = 0; wide = 0; p28 = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      tick();
      c28 += int'(ce_28m);
      if (ce_28m && p28) wide++;
      p28 = ce_28m;
    end
    check("ntsc_count_in_range", 32'(c28 >= 33069 && c28 <= 33071), 32'd1);
    check("ntsc_back_to_back", wide, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
